// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Redirect, instruction-memory and fetch-queue channels of the
//               fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_pkg::*;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;

    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_inst;

    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] fq_pc;
    logic [31:0] fq_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_inst,
        output imem_resp_ready,
        output fq_valid, fq_pc, fq_inst,
        input  fq_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_inst,
        input  imem_resp_ready,
        input  fq_valid, fq_pc, fq_inst,
        output fq_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with push, pop, flush, count, full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and fetch-request issuer; pairs returned words with
//               their PCs in a credit-protected fetch queue feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          FQ_DEPTH        = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int IF_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);

    logic [31:0]         r_pc;
    logic [IF_W-1:0]     r_inflight;
    logic [IF_W-1:0]     r_drop;

    logic                w_req_fire;
    logic                w_resp_fire;
    logic                w_drop_resp;
    logic                w_fq_push;
    logic                w_fq_pop;
    logic                w_fq_full;
    logic                w_fq_empty;
    logic [FQ_CNT_W-1:0] w_fq_cnt;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic [IF_W-1:0]     w_tag_cnt;
    logic [31:0]         w_tag_pc;
    logic [31:0]         w_credit_used;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;
    logic [ENTRY_W-1:0]  w_head_bits;
    logic                w_unused;

    // Every issued request reserves a queue slot, so responses never need to stall
    assign w_credit_used      = 32'(r_inflight) + 32'(w_fq_cnt);
    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                              && (32'(r_inflight) < 32'(MAX_OUTSTANDING))
                              && (w_credit_used < 32'(FQ_DEPTH));
    assign bus.imem_req_addr  = r_pc;
    assign bus.imem_resp_ready = !rst;

    assign w_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign w_resp_fire = bus.imem_resp_valid && bus.imem_resp_ready;
    assign w_drop_resp = (r_drop != '0) || bus.redirect_valid;
    assign w_fq_push   = w_resp_fire && !w_drop_resp;
    assign w_fq_pop    = bus.fq_valid && bus.fq_ready;

    assign w_push_entry = '{pc: w_tag_pc, inst: bus.imem_resp_inst};
    assign w_head       = w_head_bits;
    assign bus.fq_valid = !rst && !w_fq_empty;
    assign bus.fq_pc    = w_head.pc;
    assign bus.fq_inst  = w_head.inst;

    assign w_unused = &{1'b0, w_tag_full, w_tag_empty, w_tag_cnt, w_fq_full,
                        bus.redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else if (w_req_fire) begin
                r_pc <= r_pc + 32'(INST_BYTES);
            end

            r_inflight <= r_inflight + IF_W'(w_req_fire) - IF_W'(w_resp_fire);

            // No request fires during a redirect, so this is the post-edge inflight count
            if (bus.redirect_valid) begin
                r_drop <= r_inflight - IF_W'(w_resp_fire);
            end else if (w_resp_fire && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
        end
    end

    // Tags are never flushed: squashed responses still return and retire their tag
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (IF_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_req_fire),
        .push_data (r_pc),
        .pop       (w_resp_fire),
        .pop_data  (w_tag_pc),
        .flush     (1'b0),
        .count     (w_tag_cnt),
        .full      (w_tag_full),
        .empty     (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH),
        .CNT_W (FQ_CNT_W)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fq_push),
        .push_data (w_push_entry),
        .pop       (w_fq_pop),
        .pop_data  (w_head_bits),
        .flush     (bus.redirect_valid),
        .count     (w_fq_cnt),
        .full      (w_fq_full),
        .empty     (w_fq_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] C_WRAP_PC  = 32'hFFFF_FFF8;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; int cyc; } got_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    pend_t       pend[$];
    got_t        got[$];
    logic [31:0] req_log[$];
    int          cyc;
    logic        resp_hold;
    logic        overflow_seen;
    int          compared;
    int          mismatched;
    int          c0;
    int          gbase;
    int          rbase;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(C_RESET_PC), .MAX_OUTSTANDING(4), .FQ_DEPTH(4)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    fetch_unit #(.RESET_PC(C_WRAP_PC), .MAX_OUTSTANDING(4), .FQ_DEPTH(4)) dut_wrap (
        .clk (clk), .rst (rst_w), .bus (bus_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Instruction memory: always accepts, answers in order two cycles after a request
    initial begin
        cyc = 0;
        overflow_seen = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (bus.imem_resp_valid && bus.imem_resp_ready && pend.size() > 0)
                    pend.delete(0);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend.push_back('{addr: bus.imem_req_addr, due: cyc + 2});
                    req_log.push_back(bus.imem_req_addr);
                end
                if (bus.fq_valid && bus.fq_ready)
                    got.push_back('{pc: bus.fq_pc, inst: bus.fq_inst, cyc: cyc});
                if (dut.w_fq_push && dut.w_fq_full)
                    overflow_seen = 1'b1;
            end
            @(posedge clk);
            cyc++;
            #2;
            if (!resp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_inst  = mem_word(pend[0].addr);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_inst  = '0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dec_ready, input logic hold);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.fq_ready       = dec_ready;
        resp_hold          = hold;
        wait_cycles(2);
        rst   = 1'b0;
        c0    = cyc;
        gbase = got.size();
        rbase = req_log.size();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.fq_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b0) begin
            mismatched++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        compared++;
        if (bus.fq_valid !== 1'b0) begin
            mismatched++; $display("FAIL rst_fq_valid: got %b expected 0", bus.fq_valid);
        end
        compared++;
        if (bus.imem_resp_ready !== 1'b0) begin
            mismatched++; $display("FAIL rst_resp_ready: got %b expected 0", bus.imem_resp_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b1) begin
            mismatched++; $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid);
        end
        compared++;
        if (bus.imem_req_addr !== 32'h0000_0100) begin
            mismatched++; $display("FAIL first_req_addr: got %h expected 00000100", bus.imem_req_addr);
        end
        compared++;
        if (bus.imem_resp_ready !== 1'b1) begin
            mismatched++; $display("FAIL resp_ready_run: got %b expected 1", bus.imem_resp_ready);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b0);
        wait_cycles(14);
        compared++;
        if (got.size() < gbase + 8) begin
            mismatched++; $display("FAIL stream_count: got %0d entries expected at least 8", got.size() - gbase);
        end else begin
            compared++;
            if (got[gbase].cyc !== c0 + 3) begin
                mismatched++; $display("FAIL stream_latency: got cycle %0d expected %0d", got[gbase].cyc, c0 + 3);
            end
            compared++;
            if (got[gbase].inst !== 32'hFEFF_0100) begin
                mismatched++; $display("FAIL stream_inst0: got %h expected FEFF0100", got[gbase].inst);
            end
            for (int i = 0; i < 8; i++) begin
                compared++;
                if (got[gbase+i].pc !== C_RESET_PC + 32'(4 * i) ||
                    got[gbase+i].inst !== mem_word(C_RESET_PC + 32'(4 * i))) begin
                    mismatched++;
                    $display("FAIL stream_entry%0d: got pc %h inst %h expected pc %h", i,
                             got[gbase+i].pc, got[gbase+i].inst, C_RESET_PC + 32'(4 * i));
                end
                compared++;
                if (got[gbase+i].cyc !== got[gbase].cyc + i) begin
                    mismatched++;
                    $display("FAIL stream_rate%0d: got cycle %0d expected %0d", i,
                             got[gbase+i].cyc, got[gbase].cyc + i);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0, 1'b0);
        wait_cycles(8);
        compared++;
        if (req_log.size() - rbase !== 4) begin
            mismatched++; $display("FAIL stall_req_count: got %0d expected 4", req_log.size() - rbase);
        end
        @(negedge clk);
        compared++;
        if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h0000_0100 || bus.fq_inst !== 32'hFEFF_0100) begin
            mismatched++;
            $display("FAIL stall_head: got valid %b pc %h inst %h expected 1 00000100 FEFF0100",
                     bus.fq_valid, bus.fq_pc, bus.fq_inst);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (bus.imem_req_valid !== 1'b0) begin
                mismatched++; $display("FAIL stall_req_valid%0d: got %b expected 0", i, bus.imem_req_valid);
            end
        end
        compared++;
        if (got.size() !== gbase) begin
            mismatched++; $display("FAIL stall_no_pop: got %0d entries expected 0", got.size() - gbase);
        end
        @(posedge clk); #1;
        bus.fq_ready = 1'b1;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (got.size() <= gbase + i) begin
                mismatched++; $display("FAIL stall_release_count: got %0d entries expected at least %0d", got.size() - gbase, i + 1);
            end else if (got[gbase+i].pc !== C_RESET_PC + 32'(4 * i) ||
                         got[gbase+i].inst !== mem_word(C_RESET_PC + 32'(4 * i))) begin
                mismatched++;
                $display("FAIL stall_release%0d: got pc %h inst %h expected pc %h", i,
                         got[gbase+i].pc, got[gbase+i].inst, C_RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008};
        do_reset(1'b1, 1'b1);
        wait_cycles(3);
        compared++;
        if (req_log.size() - rbase !== 3) begin
            mismatched++; $display("FAIL redir_inflight: got %0d expected 3", req_log.size() - rbase);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2003;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b0) begin
            mismatched++; $display("FAIL redir_no_req: got %b expected 0", bus.imem_req_valid);
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        resp_hold = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_2000) begin
            mismatched++;
            $display("FAIL redir_req: got valid %b addr %h expected 1 00002000", bus.imem_req_valid, bus.imem_req_addr);
        end
        compared++;
        if (bus.fq_valid !== 1'b0) begin
            mismatched++; $display("FAIL redir_fq_valid: got %b expected 0", bus.fq_valid);
        end
        compared++;
        if (dut.r_drop !== 3'd3) begin
            mismatched++; $display("FAIL redir_drop: got %0d expected 3", dut.r_drop);
        end
        wait_cycles(12);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (got.size() <= gbase + i) begin
                mismatched++; $display("FAIL redir_count: got %0d entries expected at least %0d", got.size() - gbase, i + 1);
            end else if (got[gbase+i].pc !== exp_pc[i] || got[gbase+i].inst !== mem_word(exp_pc[i])) begin
                mismatched++;
                $display("FAIL redir_entry%0d: got pc %h inst %h expected pc %h", i,
                         got[gbase+i].pc, got[gbase+i].inst, exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect_pop();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h0000_0100, 32'h0000_3000, 32'h0000_3004};
        do_reset(1'b1, 1'b0);
        wait_cycles(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3000;
        @(negedge clk);
        compared++;
        if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h0000_0100) begin
            mismatched++; $display("FAIL rpop_head: got valid %b pc %h expected 1 00000100", bus.fq_valid, bus.fq_pc);
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (dut.r_drop !== 3'd1) begin
            mismatched++; $display("FAIL rpop_drop: got %0d expected 1", dut.r_drop);
        end
        compared++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_3000) begin
            mismatched++;
            $display("FAIL rpop_req: got valid %b addr %h expected 1 00003000", bus.imem_req_valid, bus.imem_req_addr);
        end
        wait_cycles(10);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (got.size() <= gbase + i) begin
                mismatched++; $display("FAIL rpop_count: got %0d entries expected at least %0d", got.size() - gbase, i + 1);
            end else if (got[gbase+i].pc !== exp_pc[i] || got[gbase+i].inst !== mem_word(exp_pc[i])) begin
                mismatched++;
                $display("FAIL rpop_entry%0d: got pc %h inst %h expected pc %h", i,
                         got[gbase+i].pc, got[gbase+i].inst, exp_pc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0800, 32'h0000_0804, 32'h0000_0808};
        do_reset(1'b1, 1'b0);
        wait_cycles(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        wait_cycles(1);
        bus.redirect_pc    = 32'h0000_0800;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b0) begin
            mismatched++; $display("FAIL b2b_no_req: got %b expected 0", bus.imem_req_valid);
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0800) begin
            mismatched++;
            $display("FAIL b2b_req: got valid %b addr %h expected 1 00000800", bus.imem_req_valid, bus.imem_req_addr);
        end
        wait_cycles(10);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (got.size() <= gbase + i) begin
                mismatched++; $display("FAIL b2b_count: got %0d entries expected at least %0d", got.size() - gbase, i + 1);
            end else if (got[gbase+i].pc !== exp_pc[i] || got[gbase+i].inst !== mem_word(exp_pc[i])) begin
                mismatched++;
                $display("FAIL b2b_entry%0d: got pc %h inst %h expected pc %h", i,
                         got[gbase+i].pc, got[gbase+i].inst, exp_pc[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        @(posedge clk); #1;
        rst_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (bus_w.imem_req_valid !== 1'b1 || bus_w.imem_req_addr !== exp_addr[i]) begin
                mismatched++;
                $display("FAIL wrap_addr%0d: got valid %b addr %h expected 1 %h", i,
                         bus_w.imem_req_valid, bus_w.imem_req_addr, exp_addr[i]);
            end
        end
        @(posedge clk); #1;
        rst_w = 1'b1;
    endtask

    task automatic test_no_overflow();
        compared++;
        if (overflow_seen !== 1'b0) begin
            mismatched++; $display("FAIL fq_overflow: got %b expected 0", overflow_seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        rst_w      = 1'b1;
        resp_hold  = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.imem_req_ready   = 1'b1;
        bus.fq_ready         = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        bus_w.imem_req_ready = 1'b1;
        bus_w.imem_resp_valid = 1'b0;
        bus_w.imem_resp_inst = '0;
        bus_w.fq_ready       = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_no_overflow();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
